// File: rtl/seq_detect_ctrl.sv
// Word-level sequencer for a 001/110 Moore sequence detector: shifts each accepted word
// MSB-first into the detector, gathers its per-bit output into a flag word and hit counts.
//   state | meaning
//   IDLE  | waiting for a word
//   CLEAR | detector held in reset for one cycle
//   SHIFT | one word bit per cycle onto det_x
//   DRAIN | collect y for the last bit, register popcount
//   DONE  | result presented until out_ready
module seq_detect_ctrl #(
    parameter int W              = 8,
    parameter int RESET_PER_WORD = 1,
    parameter int TOT_W          = 16,
    localparam int CW            = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_flags,
    output logic [CW-1:0]    out_count,
    output logic [TOT_W-1:0] total_hits,
    output logic             busy,
    output logic [2:0]       ctrl_state,
    output logic             det_x,
    output logic             det_rst,
    input  logic             det_y
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam int IW = $clog2(W);
    localparam int SW = ((TOT_W > CW) ? TOT_W : CW) + 1;

    logic [2:0]       state;
    logic [W-1:0]     sh;
    logic [IW-1:0]    bits_left;
    logic [W-1:0]     flags;
    logic [W-1:0]     flags_nxt;
    logic             first_bit;
    logic             accept;
    logic [SW-1:0]    sum;

    function automatic logic [CW-1:0] popcount(input logic [W-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < W; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    assign in_ready   = (state == IDLE) && !rst;
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign ctrl_state = state;
    assign det_rst    = rst || (state == CLEAR);
    assign det_x      = (state == SHIFT) ? sh[W-1] : 1'b0;
    assign out_flags  = flags;

    assign accept    = in_valid && in_ready;
    assign first_bit = (bits_left == IW'(W - 1));
    // Detector output is one cycle behind det_x, so each y lands in the LSB and moves up.
    assign flags_nxt = {flags[W-2:0], det_y};
    assign sum       = SW'(total_hits) + SW'(out_count);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sh         <= '0;
            bits_left  <= '0;
            flags      <= '0;
            out_count  <= '0;
            total_hits <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sh        <= in_data;
                        flags     <= '0;
                        bits_left <= IW'(W - 1);
                        state     <= (RESET_PER_WORD != 0) ? CLEAR : SHIFT;
                    end
                end
                CLEAR: state <= SHIFT;
                SHIFT: begin
                    sh <= sh << 1;
                    if (!first_bit) flags <= flags_nxt;
                    if (bits_left == '0) state <= DRAIN;
                    else bits_left <= bits_left - 1'b1;
                end
                DRAIN: begin
                    flags     <= flags_nxt;
                    out_count <= popcount(flags_nxt);
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        if (sum > SW'({TOT_W{1'b1}})) total_hits <= '1;
                        else total_hits <= sum[TOT_W-1:0];
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: three instances (per-word clear, carried history, narrow total)
// each driving a behavioural 001/110 Moore detector, checked against a word-level model.
module tb_seq_detect_ctrl;

    logic clk;
    logic [2:0] rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0] det_x, det_rst, det_y;
    logic [7:0]  in_data   [3];
    logic [7:0]  out_flags [3];
    logic [3:0]  out_count [3];
    logic [15:0] th        [3];
    logic [2:0]  st        [3];
    logic [3:0]  th_c;

    int n_chk = 0;
    int n_pass = 0;
    int exp_total [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    seq_detect_ctrl #(.W(8), .RESET_PER_WORD(1), .TOT_W(16)) u_a (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_flags(out_flags[0]), .out_count(out_count[0]), .total_hits(th[0]),
        .busy(busy[0]), .ctrl_state(st[0]), .det_x(det_x[0]), .det_rst(det_rst[0]),
        .det_y(det_y[0]));

    seq_detect_ctrl #(.W(8), .RESET_PER_WORD(0), .TOT_W(16)) u_b (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_flags(out_flags[1]), .out_count(out_count[1]), .total_hits(th[1]),
        .busy(busy[1]), .ctrl_state(st[1]), .det_x(det_x[1]), .det_rst(det_rst[1]),
        .det_y(det_y[1]));

    seq_detect_ctrl #(.W(8), .RESET_PER_WORD(1), .TOT_W(4)) u_c (
        .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_flags(out_flags[2]), .out_count(out_count[2]), .total_hits(th_c),
        .busy(busy[2]), .ctrl_state(st[2]), .det_x(det_x[2]), .det_rst(det_rst[2]),
        .det_y(det_y[2]));

    assign th[2] = {12'd0, th_c};

    // Moore detector: y registered, asserted once the last three inputs are 001 or 110.
    for (genvar k = 0; k < 3; k++) begin : g_det
        logic [1:0] h;
        logic [1:0] n;
        logic       y;
        always @(posedge clk) begin
            if (det_rst[k]) begin
                h <= 2'b00;
                n <= 2'd0;
                y <= 1'b0;
            end else begin
                y <= (n == 2'd2) && (({h, det_x[k]} == 3'b001) || ({h, det_x[k]} == 3'b110));
                h <= {h[0], det_x[k]};
                if (n != 2'd2) n <= n + 2'd1;
            end
        end
        assign det_y[k] = y;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Between words the detector is clocked with x=0, so carried history is always two zeros.
    function automatic logic [7:0] ref_flags(input logic [7:0] w, input bit carry);
        int s[$];
        int p, v;
        logic [7:0] f;
        if (carry) begin
            s.push_back(0);
            s.push_back(0);
        end
        for (int i = 7; i >= 0; i--) s.push_back(int'(w[i]));
        f = '0;
        for (int i = 0; i < 8; i++) begin
            p = s.size() - 8 + i;
            if (p >= 2) begin
                v = s[p-2] * 4 + s[p-1] * 2 + s[p];
                if (v == 1 || v == 6) f[7-i] = 1'b1;
            end
        end
        return f;
    endfunction

    function automatic int sat_add(input int k, input int a, input int b);
        int mx;
        mx = (k == 2) ? 15 : 65535;
        return (a + b > mx) ? mx : a + b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_word(input int k, input logic [7:0] w, input int hold);
        logic [7:0] ef;
        int ec, lat, t;
        bit rpw;
        rpw = (k != 1);
        ef = ref_flags(w, !rpw);
        ec = $countones(ef);
        in_data[k] = w;
        in_valid[k] = 1'b1;
        t = 0;
        while (!in_ready[k] && t < 50) begin
            tick();
            t++;
        end
        chk("in_ready before accept", 32'(in_ready[k]), 1);
        tick();
        in_valid[k] = 1'b0;
        lat = 1;
        while (!out_valid[k] && lat < 50) begin
            tick();
            lat++;
        end
        chk("latency", lat, rpw ? 11 : 10);
        chk("out_flags", 32'(out_flags[k]), 32'(ef));
        chk("out_count", 32'(out_count[k]), ec);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold out_valid", 32'(out_valid[k]), 1);
            chk("hold flags", 32'(out_flags[k]), 32'(ef));
            chk("hold in_ready", 32'(in_ready[k]), 0);
            chk("hold total", 32'(th[k]), exp_total[k]);
        end
        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
        exp_total[k] = sat_add(k, exp_total[k], ec);
        chk("total_hits", 32'(th[k]), exp_total[k]);
        chk("back to idle", 32'(st[k]), 0);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] w;
        int sent, got, t;
        bit acc;
        rst = 3'b111;
        in_valid = '0;
        out_ready = '0;
        for (int k = 0; k < 3; k++) begin
            in_data[k] = '0;
            exp_total[k] = 0;
        end
        repeat (3) tick();
        chk("rst state", 32'(st[0]), 0);
        chk("rst out_valid", 32'(out_valid[0]), 0);
        chk("rst det_rst", 32'(det_rst[0]), 1);
        chk("rst det_x", 32'(det_x[0]), 0);
        chk("rst in_ready", 32'(in_ready[0]), 0);
        chk("rst busy", 32'(busy[1]), 0);
        chk("rst total", 32'(th[1]), 0);
        chk("rst count", 32'(out_count[2]), 0);
        chk("rst flags", 32'(out_flags[2]), 0);
        rst = 3'b000;
        repeat (3) tick();
        chk("idle in_ready", 32'(in_ready[0]), 1);
        chk("idle det_rst", 32'(det_rst[0]), 0);

        // Directed words: cleared detector vs carried history.
        run_word(0, 8'b00110011, 0);
        run_word(1, 8'h00, 0);
        run_word(1, 8'b10000000, 0);
        chk("carry spans words", 32'(out_flags[1]), 32'h80);
        run_word(0, 8'h00, 0);
        run_word(0, 8'b10000000, 0);
        chk("cleared no span", 32'(out_flags[0]), 32'h00);
        run_word(0, 8'b01100110, 5);

        // Random words with random consumer stall.
        for (int i = 0; i < 12; i++) begin
            run_word(0, 8'($urandom), int'($urandom_range(0, 3)));
            run_word(1, 8'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a word.
        in_data[0] = 8'hA5;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        t = 0;
        while (st[0] != 3'd2 && t < 20) begin
            tick();
            t++;
        end
        chk("reached shift", 32'(st[0]), 2);
        repeat (4) tick();
        rst[0] = 1'b1;
        tick();
        chk("midrst state", 32'(st[0]), 0);
        chk("midrst out_valid", 32'(out_valid[0]), 0);
        chk("midrst det_rst", 32'(det_rst[0]), 1);
        chk("midrst total", 32'(th[0]), 0);
        rst[0] = 1'b0;
        exp_total[0] = 0;
        tick();
        run_word(0, 8'b11011011, 0);
        chk("post-rst flags", 32'(out_flags[0]), 32'h24);

        // Saturating 4-bit total.
        for (int i = 0; i < 6; i++) run_word(2, 8'b00110011, 0);
        chk("saturated total", 32'(th[2]), 15);

        // Producer holds in_valid high; consumer always ready.
        out_ready[0] = 1'b1;
        in_data[0] = 8'($urandom);
        in_valid[0] = 1'b1;
        sent = 0;
        got = 0;
        for (int c = 0; c < 400 && got < 8; c++) begin
            acc = 1'b0;
            if (in_ready[0]) begin
                chk("stream ready only idle", 32'(st[0]), 0);
                q.push_back(in_data[0]);
                acc = 1'b1;
            end
            if (out_valid[0]) begin
                if (q.size() > 0) begin
                    w = q.pop_front();
                    chk("stream flags", 32'(out_flags[0]), 32'(ref_flags(w, 1'b0)));
                    exp_total[0] = sat_add(0, exp_total[0], $countones(ref_flags(w, 1'b0)));
                end else begin
                    chk("stream spurious result", 1, 0);
                end
                got++;
            end
            tick();
            if (acc) begin
                sent++;
                if (sent == 8) in_valid[0] = 1'b0;
                else in_data[0] = 8'($urandom);
            end
        end
        out_ready[0] = 1'b0;
        chk("stream results", got, 8);
        chk("stream accepts", sent, 8);
        chk("stream total", 32'(th[0]), exp_total[0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
